// File: rtl/fir_filter_axil_mac.sv
// AXI4-Lite slave around a sequential single-MAC FIR filter: coefficient bank, sample
// delay line, one tap per clock, result saturated to signed 32 bits.
module fir_filter_axil_mac #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_TAPS           = 8,
    parameter int SAMPLE_WIDTH       = 16,
    parameter int COEF_WIDTH         = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int ACC_W = SAMPLE_WIDTH + COEF_WIDTH + TAP_W;
    localparam int EW    = (ACC_W > 33) ? ACC_W : 33;
    localparam logic signed [EW-1:0] SAT_HI = EW'(33'sh0_7FFF_FFFF);
    localparam logic signed [EW-1:0] SAT_LO = EW'(-33'sh0_8000_0000);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    state_t state, state_nx;

    logic                           awready, bvalid, arready, rvalid;
    logic [1:0]                     bresp, rresp;
    logic [DW-1:0]                  rdata;
    logic                           irq_en, done, overrun;
    logic [31:0]                    result;
    logic signed [COEF_WIDTH-1:0]   coef [NUM_TAPS];
    logic signed [SAMPLE_WIDTH-1:0] hist [NUM_TAPS];
    logic signed [ACC_W-1:0]        acc;
    logic [TAP_W-1:0]               tap;
    logic signed [SAMPLE_WIDTH+COEF_WIDTH-1:0] prod;

    logic            busy, wr_hs, rd_hs;
    int unsigned     wr_idx, rd_idx;
    logic            wr_is_ctrl, wr_is_status, wr_is_sample, wr_is_coef, wr_mapped;
    logic            wr_block, wr_err, sample_go, clr_go, coef_we;
    logic [TAP_W-1:0] wr_ci, rd_ci;
    logic [DW-1:0]   coef_merged, rd_data;
    logic            rd_err;

    function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] a);
        logic signed [EW-1:0] e;
        e = EW'(a);
        if (e > SAT_HI)      return 32'h7FFF_FFFF;
        else if (e < SAT_LO) return 32'h8000_0000;
        else                 return 32'(e);
    endfunction

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], coef_merged};

    assign busy  = (state != IDLE);
    assign wr_hs = awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs = arready && S_AXI_ARVALID;

    always_comb begin
        wr_idx       = 32'(S_AXI_AWADDR[AW-1:2]);
        wr_is_ctrl   = (wr_idx == 0);
        wr_is_status = (wr_idx == 1);
        wr_is_sample = (wr_idx == 2);
        wr_is_coef   = (wr_idx >= 4) && (wr_idx < 4 + NUM_TAPS);
        wr_mapped    = (wr_idx < 4) || wr_is_coef;
        // Anything that would disturb the running MAC is refused and flagged as an overrun.
        wr_block     = busy && (wr_is_sample || wr_is_coef ||
                                (wr_is_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[1]));
        wr_err       = !wr_mapped || wr_block;
        sample_go    = wr_hs && wr_is_sample && !busy;
        clr_go       = wr_hs && wr_is_ctrl && S_AXI_WSTRB[0] && S_AXI_WDATA[1] && !busy;
        coef_we      = wr_hs && wr_is_coef && !busy;
        wr_ci        = TAP_W'(wr_idx - 32'd4);
        coef_merged  = DW'(signed'(coef[wr_ci]));
        for (int b = 0; b < DW/8; b++)
            if (S_AXI_WSTRB[b]) coef_merged[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end

    always_comb begin
        rd_idx  = 32'(S_AXI_ARADDR[AW-1:2]);
        rd_ci   = TAP_W'(rd_idx - 32'd4);
        rd_data = '0;
        rd_err  = 1'b0;
        if (rd_idx == 0)      rd_data = DW'(irq_en);
        else if (rd_idx == 1) rd_data = DW'({overrun, done, busy});
        else if (rd_idx == 2) rd_data = '0;
        else if (rd_idx == 3) rd_data = DW'(result);
        else if (rd_idx >= 4 && rd_idx < 4 + NUM_TAPS) rd_data = DW'(signed'(coef[rd_ci]));
        else                  rd_err  = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_go) state_nx = MAC;
            MAC:     if (tap == TAP_W'(NUM_TAPS - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        prod = hist[tap] * coef[tap];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
            rdata   <= '0;
        end else begin
            awready <= !awready && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
            if (wr_hs) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            arready <= !arready && S_AXI_ARVALID && !rvalid;
            if (rd_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= rd_err ? 2'b10 : 2'b00;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq_en  <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (wr_hs && wr_is_ctrl && S_AXI_WSTRB[0]) irq_en <= S_AXI_WDATA[0];
            if (wr_hs && wr_is_status && S_AXI_WSTRB[0]) begin
                if (S_AXI_WDATA[1]) done    <= 1'b0;
                if (S_AXI_WDATA[2]) overrun <= 1'b0;
            end
            if (wr_hs && wr_block) overrun <= 1'b1;
            if (state == DONE)     done    <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= '0;
                hist[k] <= '0;
            end
            acc    <= '0;
            tap    <= '0;
            result <= '0;
        end else begin
            if (coef_we) coef[wr_ci] <= COEF_WIDTH'(coef_merged);
            if (clr_go) begin
                for (int k = 0; k < NUM_TAPS; k++) hist[k] <= '0;
            end else if (sample_go) begin
                hist[0] <= S_AXI_WDATA[SAMPLE_WIDTH-1:0];
                for (int k = 1; k < NUM_TAPS; k++) hist[k] <= hist[k-1];
            end
            case (state)
                IDLE: if (sample_go) begin
                    acc <= '0;
                    tap <= '0;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    tap <= tap + 1'b1;
                end
                DONE:    result <= sat32(acc);
                default: ;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = awready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign irq           = irq_en && done;

endmodule

// File: tb/tb_fir_filter_axil_mac.sv
// Directed, table-driven bench for fir_filter_axil_mac (NUM_TAPS=8, 16-bit samples/coefs).
module tb_fir_filter_axil_mac;
    localparam int NT = 8;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    fir_filter_axil_mac #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_TAPS(NT),
        .SAMPLE_WIDTH(16), .COEF_WIDTH(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .irq(irq)
    );

    typedef struct { logic [5:0] addr; logic [31:0] data; logic [1:0] resp; } rd_vec_t;
    typedef struct { logic [31:0] sample; logic [31:0] result; } push_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge ACLK); n++; end
        if (!awready) begin
            n_assert++; n_fail++;
            $display("FAIL write_timeout: actual=no AWREADY required=AWREADY addr=0x%02h", a);
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'b11;
            return;
        end
        @(posedge ACLK);
        #1;
        hs_cyc = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge ACLK);
        if (!bvalid) begin
            n_assert++; n_fail++;
            $display("FAIL bvalid_timeout: actual=0 required=1 addr=0x%02h", a);
        end
        resp = bresp;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge ACLK); n++; end
        if (!arready) begin
            n_assert++; n_fail++;
            $display("FAIL read_timeout: actual=no ARREADY required=ARREADY addr=0x%02h", a);
            arvalid = 1'b0; d = 'x; resp = 2'b11;
            return;
        end
        @(posedge ACLK);
        #1;
        arvalid = 1'b0;
        @(negedge ACLK);
        if (!rvalid) begin
            n_assert++; n_fail++;
            $display("FAIL rvalid_timeout: actual=0 required=1 addr=0x%02h", a);
        end
        d = rdata; resp = rresp;
    endtask

    task automatic wait_irq(output int lat);
        int n;
        n = 0;
        while (!irq && n < 40) begin @(negedge ACLK); n++; end
        lat = cyc - hs_cyc;
        check("irq_set", irq, 1);
    endtask

    // Push one sample, wait for completion, fetch RESULT, then W1C the done flag.
    task automatic push_wait(input logic [31:0] s, output logic [31:0] res, output int lat);
        logic [1:0] r;
        axi_write(6'h08, s, 4'hF, r);
        check("push_bresp", r, 2'b00);
        wait_irq(lat);
        axi_read(6'h0C, res, r);
        axi_write(6'h04, 32'h2, 4'h1, r);
        check("irq_clear", irq, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_vec_t     rst_tab [12];
        push_vec_t   imp_tab [NT];
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;

        for (int i = 0; i < 12; i++) rst_tab[i] = '{addr: 6'(4 * i), data: 32'h0, resp: 2'b00};
        for (int i = 0; i < NT; i++) imp_tab[i] = '{sample: (i == 0) ? 32'd1 : 32'd0, result: 32'(i + 1)};

        // Reset: outputs idle while held, every mapped register reads zero afterwards.
        #200;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rresp", rresp, 0);
        check("rst_irq", irq, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < 12; i++) begin
            axi_read(rst_tab[i].addr, d, r);
            check($sformatf("rst_read_0x%02h", rst_tab[i].addr), d, rst_tab[i].data);
            check($sformatf("rst_rresp_0x%02h", rst_tab[i].addr), r, rst_tab[i].resp);
        end

        // Impulse response through coefficients k+1.
        for (int k = 0; k < NT; k++) axi_write(6'(16 + 4 * k), 32'(k + 1), 4'hF, r);
        axi_write(6'h00, 32'h1, 4'hF, r);
        for (int i = 0; i < NT; i++) begin
            push_wait(imp_tab[i].sample, d, lat);
            check($sformatf("impulse_result_%0d", i), d, imp_tab[i].result);
            check($sformatf("done_latency_%0d", i), 32'(lat), 32'(NT + 1));
        end

        // Overrun: second push during MAC is refused; result comes from the first only.
        axi_write(6'h08, 32'd3, 4'hF, r);
        axi_write(6'h08, 32'd100, 4'hF, r);
        check("overrun_bresp", r, 2'b10);
        axi_read(6'h04, d, r);
        check("status_busy_overrun", d, 32'h5);
        wait_irq(lat);
        axi_read(6'h0C, d, r);
        check("overrun_result", d, 32'd3);
        axi_read(6'h04, d, r);
        check("status_done_overrun", d, 32'h6);
        axi_write(6'h04, 32'h6, 4'h1, r);
        axi_read(6'h04, d, r);
        check("status_w1c", d, 32'h0);

        // Coefficient write while busy is refused.
        axi_write(6'h08, 32'd0, 4'hF, r);
        axi_write(6'h18, 32'h1234, 4'hF, r);
        check("coef_busy_bresp", r, 2'b10);
        wait_irq(lat);
        axi_read(6'h0C, d, r);
        check("coef_busy_result", d, 32'd6);
        axi_read(6'h18, d, r);
        check("coef_busy_unchanged", d, 32'd3);
        axi_write(6'h04, 32'h6, 4'h1, r);

        // Unmapped offsets and byte strobes.
        axi_read(6'(16 + 4 * NT), d, r);
        check("unmapped_rdata", d, 32'h0);
        check("unmapped_rresp", r, 2'b10);
        axi_write(6'h34, 32'h5, 4'hF, r);
        check("unmapped_bresp", r, 2'b10);
        axi_write(6'h10, 32'h0, 4'hF, r);
        axi_write(6'h10, 32'hFFFF, 4'h1, r);
        check("strobe_bresp", r, 2'b00);
        axi_read(6'h10, d, r);
        check("strobe_coef0", d, 32'h0000_00FF);

        // Saturation in both directions.
        for (int k = 0; k < NT; k++) axi_write(6'(16 + 4 * k), 32'h7FFF, 4'hF, r);
        for (int i = 0; i < NT; i++) push_wait(32'h7FFF, d, lat);
        check("sat_positive", d, 32'h7FFF_FFFF);
        for (int k = 0; k < NT; k++) axi_write(6'(16 + 4 * k), 32'h8000, 4'h3, r);
        axi_read(6'h1C, d, r);
        check("coef_sign_extend", d, 32'hFFFF_8000);
        push_wait(32'h7FFF, d, lat);
        check("sat_negative", d, 32'h8000_0000);

        // Reset three cycles into MAC discards everything.
        axi_write(6'h08, 32'h100, 4'hF, r);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        #1;
        check("midmac_rst_irq", irq, 0);
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        axi_read(6'h04, d, r);
        check("midmac_status", d, 32'h0);
        axi_read(6'h0C, d, r);
        check("midmac_result", d, 32'h0);
        for (int k = 0; k < NT; k++) axi_write(6'(16 + 4 * k), 32'(k + 1), 4'hF, r);
        axi_write(6'h00, 32'h1, 4'hF, r);
        push_wait(32'd5, d, lat);
        check("post_reset_result", d, 32'd5);

        // clr_hist zeroes history and reads back as zero.
        axi_write(6'h00, 32'h3, 4'hF, r);
        axi_read(6'h00, d, r);
        check("ctrl_self_clear", d, 32'h1);
        push_wait(32'd7, d, lat);
        check("clr_hist_result", d, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
